sr_bank_arbiter: RTL and testbench

Round-robin controller that shares one bank of `WIDTH` SR flip-flops among `NREQ` requesters. Each requester presents a per-bit set/reset command vector. The arbiter grants one requester at a time, drives a single-cycle S/R strobe into the bank, and acknowledges completion. It sits between the control agents and the SR status-bit bank, and is the only writer of that bank.

---
 rtl/sr_ctrl_pkg.sv | 42 ++++
 rtl/sr_bank.sv | 34 +++
 rtl/sr_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_sr_bank_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types, SR command encodings and the round-robin pick helper
// for the SR bank arbiter and its bank.
package sr_ctrl_pkg;

  // Largest requester count the pointer and pick vector can address.
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Per-bit {S,R} command encodings. {1,1} is a defined hold, same as SR_HOLD.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_RST  = 2'b01;

  // One-hot pick of the first set request at or after ptr, wrapping modulo nreq.
  // Returns all zeros when no request is set.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int                 nreq
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (!found && (k < nreq) && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sr_bank.sv
// Bank of WIDTH SR status flops. Each bit sets on S=1/R=0, clears on
// S=0/R=1 and holds otherwise, including the S=R=1 case.
module sr_bank #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_r,
  output logic [WIDTH-1:0] o_q
);

  import sr_ctrl_pkg::*;

  logic [WIDTH-1:0] r_q;

  // Apply the per-bit SR rule on every edge; idle strobes simply hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({i_s[i], i_r[i]})
          SR_SET:  r_q[i] <= 1'b1;
          SR_RST:  r_q[i] <= 1'b0;
          default: r_q[i] <= r_q[i];
        endcase
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters take turns writing one
// SR status bank. One operation is IDLE -> GRANT -> APPLY -> IDLE; the
// granted command is latched at the end of GRANT and strobed in APPLY.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_set_vec,
  input  logic [NREQ*WIDTH-1:0] i_rst_vec,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_ack,
  output logic [WIDTH-1:0]      o_s,
  output logic [WIDTH-1:0]      o_r,
  output logic [WIDTH-1:0]      o_q,
  output logic                  o_busy
);

  import sr_ctrl_pkg::*;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gidx;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_ack;
  logic [WIDTH-1:0]   r_cmd_s;
  logic [WIDTH-1:0]   r_cmd_r;
  logic               r_busy;

  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [NREQ-1:0]    w_pick_oh;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [WIDTH-1:0]   w_sel_s;
  logic [WIDTH-1:0]   w_sel_r;
  logic [WIDTH-1:0]   w_q;

  // Round-robin choice among the live requests, as an index and a one-hot grant.
  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NREQ-1:0]   = i_req;
    w_pick                = rr_pick(w_req_ext, r_ptr, NREQ);
    w_pick_idx            = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (w_pick[k]) begin
        w_pick_idx = PTR_W'(k);
      end
    end
    w_pick_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pick_oh[i] = (w_pick_idx == PTR_W'(i));
    end
  end

  // Select the granted requester's set/reset slice for latching at the end of GRANT.
  always_comb begin
    w_sel_s = '0;
    w_sel_r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        w_sel_s = i_set_vec[i*WIDTH +: WIDTH];
        w_sel_r = i_rst_vec[i*WIDTH +: WIDTH];
      end
    end
  end

  // Fairness pointer moves to the requester just after the one being served.
  always_comb begin
    w_ptr_next = (r_gidx == PTR_W'(NREQ-1)) ? '0 : r_gidx + PTR_W'(1);
  end

  // Arbitration FSM with registered grant, ack, busy and strobe outputs.
  // The latched command doubles as the strobe: it is loaded on entry to
  // APPLY and cleared on exit, so S/R are nonzero only during APPLY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_cmd_s <= '0;
      r_cmd_r <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gidx  <= w_pick_idx;
            r_gnt   <= w_pick_oh;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_cmd_s <= w_sel_s;
          r_cmd_r <= w_sel_r;
          r_state <= APPLY;
        end
        APPLY: begin
          r_ack   <= r_gnt;
          r_gnt   <= '0;
          r_ptr   <= w_ptr_next;
          r_cmd_s <= '0;
          r_cmd_r <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_cmd_s <= '0;
          r_cmd_r <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  sr_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_s     (r_cmd_s),
    .i_r     (r_cmd_r),
    .o_q     (w_q)
  );

  assign o_gnt  = r_gnt;
  assign o_ack  = r_ack;
  assign o_s    = r_cmd_s;
  assign o_r    = r_cmd_r;
  assign o_q    = w_q;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed testbench for sr_bank_arbiter: a table of single-requester
// operations plus hand-written fairness, latching, reset and drop cases.
module tb_sr_bank_arbiter;

  import sr_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] setVec;
  logic [NREQ*WIDTH-1:0] rstVec;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      sOut;
  logic [WIDTH-1:0]      rOut;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         reqIdx;
    logic [7:0] setVal;
    logic [7:0] rstVal;
    logic [7:0] expQ;
  } vec_t;

  vec_t vectors[7];

  sr_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_set_vec (setVec),
    .i_rst_vec (rstVec),
    .o_gnt     (gnt),
    .o_ack     (ack),
    .o_s       (sOut),
    .o_r       (rOut),
    .o_q       (q),
    .o_busy    (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] setVal, input logic [7:0] rstVal);
    setVec                     = '0;
    rstVec                     = '0;
    setVec[idx*WIDTH +: WIDTH] = setVal;
    rstVec[idx*WIDTH +: WIDTH] = rstVal;
    req                        = '0;
    req[idx]                   = 1'b1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " q"},    32'(q),    32'h0);
    checkOutput({tag, " gnt"},  32'(gnt),  32'h0);
    checkOutput({tag, " ack"},  32'(ack),  32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " s"},    32'(sOut), 32'h0);
    checkOutput({tag, " r"},    32'(rOut), 32'h0);
  endtask

  task automatic doReset();
    req    = '0;
    rst_n  = 1'b0;
    #2;
    checkIdleOutputs("reset");
    rst_n  = 1'b1;
    #2;
  endtask

  initial begin
    vectors[0] = '{0, 8'hA5, 8'h00, 8'hA5};
    vectors[1] = '{1, 8'hF0, 8'h0F, 8'hF0};
    vectors[2] = '{1, 8'h0C, 8'h30, 8'hCC};
    vectors[3] = '{1, 8'hFF, 8'hFF, 8'hCC};
    vectors[4] = '{3, 8'h00, 8'h0C, 8'hC0};
    vectors[5] = '{2, 8'h03, 8'h80, 8'h43};
    vectors[6] = '{0, 8'h00, 8'h00, 8'h43};

    rst_n  = 1'b0;
    req    = '0;
    setVec = '0;
    rstVec = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("power-on reset");
    rst_n = 1'b1;

    // Table: one full operation per record, Q carrying across records.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vectors[v].reqIdx, vectors[v].setVal, vectors[v].rstVal);
      tick();
      checkOutput($sformatf("vec%0d gnt", v),  32'(gnt),  32'(1) << vectors[v].reqIdx);
      checkOutput($sformatf("vec%0d busy", v), 32'(busy), 32'h1);
      checkOutput($sformatf("vec%0d s@grant", v), 32'(sOut), 32'h0);
      tick();
      checkOutput($sformatf("vec%0d s@apply", v), 32'(sOut), 32'(vectors[v].setVal));
      checkOutput($sformatf("vec%0d r@apply", v), 32'(rOut), 32'(vectors[v].rstVal));
      checkOutput($sformatf("vec%0d ack@apply", v), 32'(ack), 32'h0);
      tick();
      checkOutput($sformatf("vec%0d q", v),    32'(q),    32'(vectors[v].expQ));
      checkOutput($sformatf("vec%0d ack", v),  32'(ack),  32'(1) << vectors[v].reqIdx);
      checkOutput($sformatf("vec%0d gnt@idle", v), 32'(gnt), 32'h0);
      checkOutput($sformatf("vec%0d busy@idle", v), 32'(busy), 32'h0);
      checkOutput($sformatf("vec%0d s@idle", v), 32'(sOut), 32'h0);
      req = '0;
      tick();
      checkOutput($sformatf("vec%0d ack cleared", v), 32'(ack), 32'h0);
    end

    // Fairness: all four requesting from ptr=0; each sets its own bit.
    doReset();
    req    = 4'b1111;
    rstVec = '0;
    for (int i = 0; i < NREQ; i++) begin
      setVec[i*WIDTH +: WIDTH] = 8'(1 << i);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput($sformatf("rr grant %0d", n), 32'(gnt), 32'(1) << (n % NREQ));
      tick();
      tick();
      checkOutput($sformatf("rr ack %0d", n), 32'(ack), 32'(1) << (n % NREQ));
    end
    req = '0;
    checkOutput("rr q", 32'(q), 32'h0F);
    tick();

    // Command latching: the set vector changes during APPLY and must be ignored.
    doReset();
    applyStimulus(2, 8'h01, 8'h00);
    tick();
    checkOutput("latch gnt", 32'(gnt), 32'h4);
    tick();
    setVec[2*WIDTH +: WIDTH] = 8'h80;
    #1;
    checkOutput("latch s held", 32'(sOut), 32'h01);
    checkOutput("latch bit0 cmd", 32'({sOut[0], rOut[0]}), 32'(SR_SET));
    tick();
    checkOutput("latch q", 32'(q), 32'h01);
    checkOutput("latch ack", 32'(ack), 32'h4);
    req = '0;
    tick();

    // Reset during APPLY discards the command; pending requests restart from ptr=0.
    applyStimulus(0, 8'hFF, 8'h00);
    tick();
    checkOutput("midrst gnt", 32'(gnt), 32'h1);
    tick();
    checkOutput("midrst s@apply", 32'(sOut), 32'hFF);
    rst_n  = 1'b0;
    req    = 4'b1010;
    setVec = '0;
    rstVec = '0;
    setVec[1*WIDTH +: WIDTH] = 8'h02;
    setVec[3*WIDTH +: WIDTH] = 8'h40;
    #1;
    checkIdleOutputs("midrst");
    tick();
    checkOutput("midrst ack held low", 32'(ack), 32'h0);
    checkOutput("midrst q held low", 32'(q), 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("regrant from ptr0", 32'(gnt), 32'h2);
    tick();
    tick();
    checkOutput("regrant ack", 32'(ack), 32'h2);
    checkOutput("regrant q", 32'(q), 32'h02);
    req = 4'b1000;

    // Requester 3 drops req during GRANT; the operation still completes.
    tick();
    checkOutput("drop gnt", 32'(gnt), 32'h8);
    req = '0;
    tick();
    checkOutput("drop busy", 32'(busy), 32'h1);
    tick();
    checkOutput("drop ack", 32'(ack), 32'h8);
    checkOutput("drop q", 32'(q), 32'h42);
    req = 4'b1111;
    tick();
    checkOutput("ptr wrap to 0", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
